// File: rtl/threshold_scan_ctrl.sv
// -----------------------------------------------------------------------------
// threshold_scan_ctrl
//
// Sequencer for the programmable threshold sensor. It steps a 3-bit
// threshold-select code into the decoder, waits for the analog path to
// settle, takes a majority vote of the synchronized comparator output, and
// resolves the input level (number of the 8 thresholds exceeded). It uses
// either a linear sweep over all 8 codes or a binary search.
//
// Handshake (valid/ready style): start_i is accepted only while the block is
// idle (busy_o low and done_o low). Once accepted, busy_o stays high until
// the last evaluation. done_o then pulses for exactly one cycle. level_o,
// thermo_o and result_valid_o are valid from that same cycle and hold until
// the next completed conversion. abort_i returns to idle without a done
// pulse and leaves the previous result untouched.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous, active-high reset
//   start_i         begin a conversion (accepted only in IDLE)
//   abort_i         cancel a conversion in progress (ignored in DONE)
//   mode_i          0 = linear sweep, 1 = binary search (latched at start)
//   manual_code_i   code driven to the decoder while idle
//   cmp_i           asynchronous comparator output, 1 = above threshold
//   code_out_o      registered threshold select to the decoder
//   busy_o          conversion in progress
//   done_o          one-cycle pulse when the result updates
//   level_o         number of thresholds exceeded, 0..8
//   thermo_o        thermometer code, bit k = threshold k exceeded
//   result_valid_o  set by the first completed conversion
//   state_o         current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module threshold_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,  // 2..255, includes sync latency
    parameter int unsigned SAMPLES       = 4    // 1..15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       mode_i,
    input  logic [2:0] manual_code_i,
    input  logic       cmp_i,
    output logic [2:0] code_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] level_o,
    output logic [7:0] thermo_o,
    output logic       result_valid_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SET    = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_EVAL   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // Counter reload values: the counter runs down to zero, so a phase of N
    // cycles loads N-1.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLES - 1);
    localparam logic [4:0] SAMPLES_W   = 5'(SAMPLES);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    // Thermometer code with the lowest lvl bits set (lvl may be 8 -> 0xFF).
    function automatic logic [7:0] thermo_of(input logic [3:0] lvl);
        logic [7:0] t;
        t = '0;
        for (int k = 0; k < 8; k++) begin
            t[k] = (4'(k) < lvl);
        end
        return t;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;        // settle / sample down-counter
    logic [3:0] ones_q, ones_d;      // comparator ones in the current step
    logic [2:0] idx_q, idx_d;        // linear sweep position
    logic [3:0] lo_q, lo_d;          // binary search bounds, 0..8
    logic [3:0] hi_q, hi_d;
    logic       mode_q, mode_d;      // mode latched at start
    logic [7:0] scratch_q, scratch_d;
    logic [3:0] level_q, level_d;
    logic [7:0] thermo_q, thermo_d;
    logic       valid_q, valid_d;

    // Two-flop synchronizer for the asynchronous comparator output.
    logic       sync1_q;
    logic       cmp_s_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [2:0] mid;
    logic [2:0] target;
    logic       decision;
    logic [3:0] lo_nxt;
    logic [3:0] hi_nxt;
    logic [7:0] scratch_nxt;
    logic       abort_now;

    // While a search is running lo < hi <= 8, so lo+hi <= 15 and the
    // midpoint always fits in 3 bits.
    assign mid      = 3'((lo_q + hi_q) >> 1);
    assign target   = mode_q ? mid : idx_q;
    // Strict majority; a tie counts as "not exceeded".
    assign decision = ({ones_q, 1'b0} > SAMPLES_W);
    // DONE is already committed to the result, so abort has no effect there.
    assign abort_now = abort_i && (state_q != S_IDLE) && (state_q != S_DONE);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        mode_d      = mode_q;
        scratch_d   = scratch_q;
        level_d     = level_q;
        thermo_d    = thermo_q;
        valid_d     = valid_q;
        lo_nxt      = lo_q;
        hi_nxt      = hi_q;
        scratch_nxt = scratch_q;

        unique case (state_q)
            S_IDLE: begin
                code_d = manual_code_i;
                if (start_i && !abort_i) begin
                    state_d   = S_SET;
                    mode_d    = mode_i;
                    idx_d     = '0;
                    lo_d      = 4'd0;
                    hi_d      = 4'd8;
                    scratch_d = '0;
                end
            end

            S_SET: begin
                code_d  = target;
                cnt_d   = SETTLE_LOAD;
                ones_d  = '0;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = SAMPLE_LOAD;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_SAMPLE: begin
                ones_d = ones_q + {3'b000, cmp_s_q};
                if (cnt_q == '0) begin
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_EVAL: begin
                if (mode_q) begin
                    if (decision) begin
                        lo_nxt = {1'b0, mid} + 4'd1;
                    end else begin
                        hi_nxt = {1'b0, mid};
                    end
                    lo_d = lo_nxt;
                    hi_d = hi_nxt;
                    if (lo_nxt == hi_nxt) begin
                        // Result is published on entry to DONE so it is
                        // valid in the same cycle as the done pulse.
                        level_d  = lo_nxt;
                        thermo_d = thermo_of(lo_nxt);
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_SET;
                    end
                end else begin
                    scratch_nxt[idx_q] = decision;
                    scratch_d          = scratch_nxt;
                    if (idx_q == 3'd7) begin
                        // A non-monotonic sweep is reported unchanged.
                        level_d  = popcount8(scratch_nxt);
                        thermo_d = scratch_nxt;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SET;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the current state planned: back to idle,
        // decoder code untouched this cycle, published result preserved.
        if (abort_now) begin
            state_d  = S_IDLE;
            code_d   = code_q;
            level_d  = level_q;
            thermo_d = thermo_q;
            valid_d  = valid_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            cnt_q     <= '0;
            ones_q    <= '0;
            idx_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            mode_q    <= 1'b0;
            scratch_q <= '0;
            level_q   <= '0;
            thermo_q  <= '0;
            valid_q   <= 1'b0;
            sync1_q   <= 1'b0;
            cmp_s_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            idx_q     <= idx_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            mode_q    <= mode_d;
            scratch_q <= scratch_d;
            level_q   <= level_d;
            thermo_q  <= thermo_d;
            valid_q   <= valid_d;
            sync1_q   <= cmp_i;
            cmp_s_q   <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign code_out_o     = code_q;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign level_o        = level_q;
    assign thermo_o       = thermo_q;
    assign result_valid_o = valid_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_threshold_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_threshold_scan_ctrl
//
// Directed bench for threshold_scan_ctrl with default parameters
// (SETTLE_CYCLES=16, SAMPLES=4, so one step is 22 cycles).
// Cycle 0 is the cycle in which start_i is sampled; SET is cycle 1.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_threshold_scan_ctrl;

    localparam int STEP = 22;

    // ---------------------------------------------------------------------
    // Clock / reset block
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic       mode_i;
    logic [2:0] manual_code_i;
    logic       cmp_i;
    logic [2:0] code_out_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] level_o;
    logic [7:0] thermo_o;
    logic       result_valid_o;
    logic [2:0] state_o;

    threshold_scan_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .mode_i         (mode_i),
        .manual_code_i  (manual_code_i),
        .cmp_i          (cmp_i),
        .code_out_o     (code_out_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .level_o        (level_o),
        .thermo_o       (thermo_o),
        .result_valid_o (result_valid_o),
        .state_o        (state_o)
    );

    // Free-running cycle counter, advances on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------------
    // Comparator model
    //   cmp_mode 0: threshold model, cmp = (code < true_lvl)
    //   cmp_mode 1: timed pattern, cmp high for ones_n cycles starting at
    //               step-relative cycle 15 so that exactly ones_n of the
    //               4 SAMPLE cycles (relative 17..20) see a 1 after the
    //               two-flop synchronizer.
    // ---------------------------------------------------------------------
    int         cmp_mode = 0;
    logic [3:0] true_lvl = 4'd0;
    int         ones_n   = 0;
    int         set_cyc  = 0;

    always @(negedge clk) begin
        int r;
        if (cmp_mode == 0) begin
            cmp_i = ({1'b0, code_out_o} < true_lvl);
        end else begin
            r = cyc - set_cyc;
            if (r >= 0) r = r % STEP;
            cmp_i = (r >= 15) && (r < 15 + ones_n);
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_codes [8];
    logic [2:0] man_code;
    logic       early;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string name);
        chk($sformatf("%s_code", name),  code_out_o,     32'd0);
        chk($sformatf("%s_busy", name),  busy_o,         32'd0);
        chk($sformatf("%s_done", name),  done_o,         32'd0);
        chk($sformatf("%s_level", name), level_o,        32'd0);
        chk($sformatf("%s_thermo", name), thermo_o,      32'd0);
        chk($sformatf("%s_valid", name), result_valid_o, 32'd0);
        chk($sformatf("%s_state", name), state_o,        32'd0);
    endtask

    // Runs one conversion from idle and checks the code sequence, the done
    // cycle, the result and the return to idle. With poke set, a stray start
    // and a flipped mode are presented for one cycle during step 2.
    task automatic run_conv(input string name, input logic m, input int nsteps,
                            input int exp_done, input logic [3:0] exp_lvl,
                            input logic [7:0] exp_th, input bit poke);
        bit early_done;
        early_done = 1'b0;
        mode_i  = m;
        start_i = 1'b1;
        set_cyc = cyc + 1;
        step();
        for (int c = 1; c <= exp_done; c++) begin
            int  rel;
            int  s;
            bit  p;
            rel = (c - 1) % STEP;
            s   = (c - 1) / STEP;
            if (c == 1) chk($sformatf("%s_busy_set", name), busy_o, 32'd1);
            if (c == exp_done - 1) chk($sformatf("%s_busy_last_eval", name), busy_o, 32'd1);
            if (c < exp_done) begin
                early_done |= done_o;
                if (rel == 10 && s < nsteps)
                    chk($sformatf("%s_code_step%0d", name, s), code_out_o, exp_codes[s]);
            end else begin
                chk($sformatf("%s_done", name),   done_o,         32'd1);
                chk($sformatf("%s_busy_done", name), busy_o,      32'd0);
                chk($sformatf("%s_level", name),  level_o,        exp_lvl);
                chk($sformatf("%s_thermo", name), thermo_o,       exp_th);
                chk($sformatf("%s_valid", name),  result_valid_o, 32'd1);
            end
            p       = poke && (s == 1) && (rel == 5);
            start_i = p;
            mode_i  = p ? ~m : m;
            if (c < exp_done) step();
        end
        chk($sformatf("%s_no_early_done", name), early_done, 32'd0);
        start_i = 1'b0;
        mode_i  = m;
        step();
        chk($sformatf("%s_done_one_cycle", name), done_o, 32'd0);
        chk($sformatf("%s_idle_busy", name), busy_o, 32'd0);
        step();
        chk($sformatf("%s_idle_code", name), code_out_o, man_code);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        rst_i         = 1'b1;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        mode_i        = 1'b0;
        man_code      = 3'd6;
        manual_code_i = man_code;
        step();
        step();
        step();

        // Reset state: code_out stays 0 even with a nonzero manual code.
        chk_reset_values("por");

        // Idle tracking: code_out follows manual_code one cycle later.
        rst_i = 1'b0;
        step();
        chk("idle_track_6", code_out_o, 32'd6);
        man_code      = 3'd2;
        manual_code_i = man_code;
        chk("idle_track_lag", code_out_o, 32'd6);
        step();
        chk("idle_track_2", code_out_o, 32'd2);

        // start and abort together in IDLE: nothing starts.
        man_code      = 3'd3;
        manual_code_i = man_code;
        start_i       = 1'b1;
        abort_i       = 1'b1;
        step();
        chk("sa_busy", busy_o, 32'd0);
        chk("sa_state", state_o, 32'd0);
        chk("sa_code3", code_out_o, 32'd3);
        man_code      = 3'd1;
        manual_code_i = man_code;
        step();
        chk("sa_code1", code_out_o, 32'd1);
        start_i = 1'b0;
        abort_i = 1'b0;
        early   = 1'b0;
        repeat (30) begin
            early |= done_o | busy_o;
            step();
        end
        chk("sa_no_activity", early, 32'd0);
        chk("sa_valid", result_valid_o, 32'd0);

        // Linear sweep, level 5, with a stray start/mode flip mid-run.
        cmp_mode  = 0;
        true_lvl  = 4'd5;
        exp_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        run_conv("lin5", 1'b0, 8, 177, 4'd5, 8'h1F, 1'b1);

        // Binary search, level 5, with a stray start/mode flip mid-run.
        exp_codes = '{3'd4, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        run_conv("bin5", 1'b1, 3, 67, 4'd5, 8'h1F, 1'b1);

        // Binary boundary: comparator always 0.
        true_lvl  = 4'd0;
        exp_codes = '{3'd4, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        run_conv("bin0", 1'b1, 4, 89, 4'd0, 8'h00, 1'b0);

        // Binary boundary: comparator always 1.
        true_lvl  = 4'd8;
        exp_codes = '{3'd4, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        run_conv("bin8", 1'b1, 3, 67, 4'd8, 8'hFF, 1'b0);

        // Majority vote: 2 of 4 ones is a tie -> every decision 0.
        cmp_mode  = 1;
        ones_n    = 2;
        exp_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        run_conv("maj2", 1'b0, 8, 177, 4'd0, 8'h00, 1'b0);

        // Majority vote: 3 of 4 ones -> every decision 1.
        ones_n = 3;
        run_conv("maj3", 1'b0, 8, 177, 4'd8, 8'hFF, 1'b0);

        // Abort during step 3 of a binary search (level 3: codes 4, 2, 3).
        cmp_mode = 0;
        true_lvl = 4'd3;
        mode_i   = 1'b1;
        start_i  = 1'b1;
        set_cyc  = cyc + 1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 55; c++) step();
        chk("abort_code_step2", code_out_o, 32'd3);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_busy",   busy_o,         32'd0);
        chk("abort_done",   done_o,         32'd0);
        chk("abort_state",  state_o,        32'd0);
        chk("abort_level",  level_o,        32'd8);
        chk("abort_thermo", thermo_o,       32'hFF);
        chk("abort_valid",  result_valid_o, 32'd1);
        early = 1'b0;
        repeat (100) begin
            early |= done_o | busy_o;
            step();
        end
        chk("abort_quiet", early, 32'd0);
        chk("abort_level_kept", level_o, 32'd8);

        // Reset mid-SAMPLE of step 2 of a linear sweep.
        true_lvl = 4'd5;
        mode_i   = 1'b0;
        start_i  = 1'b1;
        set_cyc  = cyc + 1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 41; c++) step();
        chk("rst_mid_busy_before", busy_o, 32'd1);
        rst_i = 1'b1;
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        rst_i   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        chk_reset_values("rst_mid");

        // A full conversion runs normally after the reset.
        exp_codes = '{3'd4, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        run_conv("post_rst", 1'b1, 3, 67, 4'd5, 8'h1F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
